// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch unit with a small in-order queue between instruction
//   memory and decode. A byte-addressed fetch PC drives a word-indexed,
//   combinational instruction memory. Each cycle, if there is room, the
//   fetched word and its PC are pushed. Decode drains the head with a
//   valid/ready handshake. A redirect flushes the queue and restarts fetch
//   at the word-aligned target.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   redirect_valid branch/jump redirect request (highest priority)
//   redirect_pc    redirect target byte address
//   imem_addr      word index presented to instruction memory
//   imem_dout      combinational read data for imem_addr
//   out_valid      head entry valid
//   out_ready      decode accepts head entry
//   out_instr      head instruction
//   out_pc         byte PC of head instruction
//   count          number of occupied entries
module fetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]   redirect_pc,
  output logic [ADDRESS_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]      imem_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [ADDRESS_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;

  // Entry storage carries data only; validity comes from pointers/count.
  logic [DATA_WIDTH-1:0]    instr_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_q    [DEPTH];

  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // DEPTH is a power of two, so natural overflow gives modulo-DEPTH wrap.
    return p + PW'(1);
  endfunction

  assign imem_addr = {2'b00, pc[ADDRESS_WIDTH-1:2]};

  assign out_valid = (count != '0);
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];

  // Both decisions use the start-of-cycle count, so a same-cycle pop never
  // opens a slot for a push when the queue is full.
  assign push = (count < CW'(DEPTH)) && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + ADDRESS_WIDTH'(4);
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_dout;
      pc_q[wr_ptr]    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Bench for fetch_queue (default parameters). Instruction memory word k
//   holds 32'h1000_0000 + k. A directed table covers streaming, fill/stall,
//   full-with-pop and redirect; hand sequences cover asynchronous reset and
//   PC wrap; a randomized phase runs against a queue-based reference model.
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [2:0]    count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign imem_dout = 32'h1000_0000 + imem_addr;

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  typedef struct {
    logic          redir;
    logic [31:0]   rpc;
    logic          ready;
    logic          exp_valid;
    logic [2:0]    exp_count;
    logic [31:0]   exp_pc;
    logic [31:0]   exp_addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  vec_t tbl [10];
  ent_t mq [$];
  logic [31:0] mpc;

  function automatic logic [31:0] mem_word(input logic [31:0] byte_pc);
    return 32'h1000_0000 + (byte_pc >> 2);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_vec(input vec_t v, input int i);
    tbl[i] = v;
  endtask

  // Reference model: one clock edge applied to the abstract queue.
  task automatic model_edge(input logic redir, input logic [31:0] rpc, input logic ready);
    bit do_push, do_pop;
    do_push = (mq.size() < DEPTH) && !redir;
    do_pop  = (mq.size() > 0) && ready && !redir;
    if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({mem_word(mpc), mpc});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic model_check(input int cyc);
    chk($sformatf("rnd%0d count", cyc), 64'(count), 64'(mq.size()));
    chk($sformatf("rnd%0d valid", cyc), 64'(out_valid), 64'(mq.size() != 0));
    chk($sformatf("rnd%0d addr", cyc), 64'(imem_addr), 64'(mpc >> 2));
    if (mq.size() != 0) begin
      chk($sformatf("rnd%0d pc", cyc), 64'(out_pc), 64'(mq[0].pc));
      chk($sformatf("rnd%0d instr", cyc), 64'(out_instr), 64'(mq[0].instr));
    end
  endtask

  initial begin
    vec_t v;
    int   r;

    // Directed vectors starting from reset: inputs for one cycle, then the
    // outputs expected after that cycle's edge.
    //          redir rpc           rdy val cnt pc            addr
    v = '{1'b0, 32'h0,        1'b1, 1'b1, 3'd1, 32'h0,   32'h1};  set_vec(v, 0);
    v = '{1'b0, 32'h0,        1'b1, 1'b1, 3'd1, 32'h4,   32'h2};  set_vec(v, 1);
    v = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd2, 32'h4,   32'h3};  set_vec(v, 2);
    v = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd3, 32'h4,   32'h4};  set_vec(v, 3);
    v = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd4, 32'h4,   32'h5};  set_vec(v, 4);
    v = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd4, 32'h4,   32'h5};  set_vec(v, 5);
    v = '{1'b0, 32'h0,        1'b1, 1'b1, 3'd3, 32'h8,   32'h5};  set_vec(v, 6);
    v = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd4, 32'h8,   32'h6};  set_vec(v, 7);
    v = '{1'b1, 32'h103,      1'b1, 1'b0, 3'd0, 32'h0,   32'h40}; set_vec(v, 8);
    v = '{1'b0, 32'h0,        1'b0, 1'b1, 3'd1, 32'h100, 32'h41}; set_vec(v, 9);

    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    #12;
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset count", 64'(count), 64'd0);
    chk("reset addr", 64'(imem_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].ready;
      step();
      chk($sformatf("vec%0d valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d count", i), 64'(count), 64'(tbl[i].exp_count));
      chk($sformatf("vec%0d addr", i), 64'(imem_addr), 64'(tbl[i].exp_addr));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d pc", i), 64'(out_pc), 64'(tbl[i].exp_pc));
        chk($sformatf("vec%0d instr", i), 64'(out_instr), 64'(mem_word(tbl[i].exp_pc)));
      end
    end

    // Asynchronous reset pulse between edges while two entries are queued.
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    step();
    chk("pre-rst count", 64'(count), 64'd2);
    #1 rst = 1'b1;
    #1;
    chk("async rst valid", 64'(out_valid), 64'd0);
    chk("async rst count", 64'(count), 64'd0);
    chk("async rst addr", 64'(imem_addr), 64'd0);
    #1 rst = 1'b0;
    step();
    chk("post-rst count", 64'(count), 64'd1);
    chk("post-rst pc", 64'(out_pc), 64'd0);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    chk("wrap redirect addr", 64'(imem_addr), 64'h3FFF_FFFF);
    chk("wrap redirect count", 64'(count), 64'd0);
    step();
    chk("wrap entry pc", 64'(out_pc), 64'hFFFF_FFFC);
    chk("wrap entry instr", 64'(out_instr), 64'h4FFF_FFFF);
    chk("wrap next addr", 64'(imem_addr), 64'd0);

    // Randomized phase against the reference model.
    rst = 1'b1;
    #1 rst = 1'b0;
    mq.delete();
    mpc = 32'h0;
    for (int c = 0; c < 2000; c++) begin
      model_check(c);
      r = int'($urandom_range(0, 99));
      redirect_valid = (r < 6);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        redirect_pc = $urandom;
      out_ready = ($urandom_range(0, 99) < 60);
      step();
      model_edge(redirect_valid, redirect_pc, out_ready);
    end
    model_check(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
